// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receiving end of the VGA stream (hsync/vsync/blank/RGB565).
// Recovers pixel coordinates from the sync edges, measures frame geometry,
// declares lock after LOCK_FRAMES consecutive good frames and counts bad
// frames seen while locked.
// Optional feature macro: FRAME_CHECKSUM_EN adds a per-frame 16-bit pixel sum
// on o_frame_sum; without it o_frame_sum is tied to zero.
module vga_rx_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 3,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0
) (
  input  logic        i_vga_clk,
  input  logic        i_sys_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_rgb_valid,
  input  logic [15:0] i_rgb,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [11:0] o_pix_x,
  output logic [11:0] o_pix_y,
  output logic        o_frame_start,
  output logic        o_locked,
  output logic [11:0] o_h_meas,
  output logic [11:0] o_v_meas,
  output logic [7:0]  o_err_cnt,
  output logic [15:0] o_frame_sum
);

  localparam logic [11:0] H_EXPECT = 12'(H_ACTIVE);
  localparam logic [11:0] V_EXPECT = 12'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKED
  } stateType;

  stateType    r_state;
  stateType    w_stateNext;
  logic [3:0]  r_lockCnt;
  logic [3:0]  w_lockCntNext;
  logic [3:0]  w_lockCntInc;
  logic        w_errInc;

  // Previous-cycle sync/valid levels are kept as "active" flags so a cleared
  // register always means inactive, whatever the configured polarity.
  logic        r_hsPrev;
  logic        r_vsPrev;
  logic        r_validPrev;
  logic [11:0] r_xCnt;
  logic [11:0] r_yCnt;
  logic        r_badFrame;

  logic        w_hsActive;
  logic        w_vsActive;
  logic        w_hsEdge;
  logic        w_vsEdge;
  logic        w_lineEnd;
  logic [11:0] w_xInc;
  logic [11:0] w_yInc;
  logic [11:0] w_yAtEdge;
  logic        w_lineBad;
  logic        w_syncOverlap;
  logic        w_frameBad;

  assign w_hsActive    = (i_hsync == HS_POL);
  assign w_vsActive    = (i_vsync == VS_POL);
  assign w_hsEdge      = w_hsActive & ~r_hsPrev;
  assign w_vsEdge      = w_vsActive & ~r_vsPrev;
  assign w_lineEnd     = r_validPrev & ~i_rgb_valid;
  assign w_xInc        = (r_xCnt == 12'hFFF) ? r_xCnt : r_xCnt + 12'd1;
  assign w_yInc        = (r_yCnt == 12'hFFF) ? r_yCnt : r_yCnt + 12'd1;
  // A line ending in the same cycle as the vsync edge still belongs to the
  // frame being closed, so it is folded into the evaluated line count.
  assign w_yAtEdge     = w_lineEnd ? w_yInc : r_yCnt;
  assign w_lineBad     = w_lineEnd && (r_xCnt != H_EXPECT);
  assign w_syncOverlap = i_rgb_valid && (w_hsActive || w_vsActive);
  assign w_frameBad    = r_badFrame | w_lineBad | w_syncOverlap |
                         (w_yAtEdge != V_EXPECT);
  assign w_lockCntInc  = r_lockCnt + 4'd1;

  // Lock FSM state and good-frame counter registers.
  always_ff @(posedge i_vga_clk) begin
    if (i_sys_rst) begin
      r_state   <= ST_SEARCH;
      r_lockCnt <= 4'd0;
    end else begin
      r_state   <= w_stateNext;
      r_lockCnt <= w_lockCntNext;
    end
  end

  // Next-state logic; the FSM only moves when a frame is closed by vsync.
  always_comb begin
    w_stateNext = r_state;
    if (w_vsEdge) begin
      case (r_state)
        ST_SEARCH:  w_stateNext = ST_MEASURE;
        ST_MEASURE: if (!w_frameBad && (w_lockCntInc == LOCK_N))
                      w_stateNext = ST_LOCKED;
        ST_LOCKED:  if (w_frameBad)
                      w_stateNext = ST_MEASURE;
        default:    w_stateNext = ST_SEARCH;
      endcase
    end
  end

  // FSM side effects: good-frame count update and error-count request.
  always_comb begin
    w_lockCntNext = r_lockCnt;
    w_errInc      = 1'b0;
    if (w_vsEdge) begin
      case (r_state)
        ST_SEARCH:  w_lockCntNext = 4'd0;
        ST_MEASURE: begin
          if (w_frameBad || (w_lockCntInc == LOCK_N))
            w_lockCntNext = 4'd0;
          else
            w_lockCntNext = w_lockCntInc;
        end
        ST_LOCKED: begin
          w_lockCntNext = 4'd0;
          w_errInc      = w_frameBad;
        end
        default:    w_lockCntNext = 4'd0;
      endcase
    end
  end

  // Input stage, coordinate counters, geometry measurement and status outputs.
  always_ff @(posedge i_vga_clk) begin
    if (i_sys_rst) begin
      r_hsPrev      <= 1'b0;
      r_vsPrev      <= 1'b0;
      r_validPrev   <= 1'b0;
      r_xCnt        <= 12'd0;
      r_yCnt        <= 12'd0;
      r_badFrame    <= 1'b0;
      o_pix_valid   <= 1'b0;
      o_pix_data    <= 16'd0;
      o_pix_x       <= 12'd0;
      o_pix_y       <= 12'd0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_h_meas      <= 12'd0;
      o_v_meas      <= 12'd0;
      o_err_cnt     <= 8'd0;
    end else begin
      r_hsPrev      <= w_hsActive;
      r_vsPrev      <= w_vsActive;
      r_validPrev   <= i_rgb_valid;
      o_pix_valid   <= i_rgb_valid;
      o_pix_data    <= i_rgb;
      o_frame_start <= w_vsEdge;
      o_locked      <= (w_stateNext == ST_LOCKED);

      if (i_rgb_valid) begin
        o_pix_x <= r_xCnt;
        o_pix_y <= r_yCnt;
      end

      if (w_hsEdge)
        r_xCnt <= 12'd0;
      else if (i_rgb_valid)
        r_xCnt <= w_xInc;

      if (w_lineEnd)
        o_h_meas <= r_xCnt;

      if (w_vsEdge) begin
        o_v_meas   <= w_yAtEdge;
        r_yCnt     <= 12'd0;
        r_badFrame <= 1'b0;
      end else begin
        if (w_lineEnd)
          r_yCnt <= w_yInc;
        if (w_lineBad || w_syncOverlap)
          r_badFrame <= 1'b1;
      end

      if (w_errInc && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] r_sumAcc;
  logic [15:0] w_sumNow;

  assign w_sumNow = r_sumAcc + (i_rgb_valid ? i_rgb : 16'h0000);

  // Running modulo-2^16 pixel sum, published and restarted at each frame edge.
  always_ff @(posedge i_vga_clk) begin
    if (i_sys_rst) begin
      r_sumAcc    <= 16'h0000;
      o_frame_sum <= 16'h0000;
    end else if (w_vsEdge) begin
      o_frame_sum <= w_sumNow;
      r_sumAcc    <= 16'h0000;
    end else begin
      r_sumAcc    <= w_sumNow;
    end
  end
`else
  assign o_frame_sum = 16'h0000;
`endif

endmodule
